sim_sequencer: RTL and testbench

Top-level timestep sequencer for the particle-in-cell engine. It is the multi-lane successor to the single-lane step controller. After the UI load, it runs a programmable number of steps. Each step runs PUSH_SCATTER, then SCATTER, then SOLVE across NUM_LANES parallel pusher/scatter lanes, and collects per-lane completion that may arrive in different cycles. It also adds an internal step counter, abort, and a per-phase watchdog.

---
 rtl/sim_sequencer_if.sv | 49 ++++
 rtl/sim_sequencer.sv | 176 +++++++++++++++++
 tb/tb_sim_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_sequencer_if.sv
// ---------------------------------------------------------------------------
// sim_sequencer_if
// Purpose : groups the control and handshake signals of the PIC timestep
//           sequencer into a single bundle.
// Signals :
//   ui_done      start pulse from the UI load (sampled only when idle)
//   num_steps    number of timesteps to run (latched with ui_done)
//   abort        synchronous abort, any state
//   pusher_done  per-lane push complete
//   scatter_done per-lane scatter complete
//   solve_done   field solve complete
//   pusher_valid high throughout PUSH_SCATTER
//   start_solve  high throughout SOLVE
//   first        high during PUSH_SCATTER of step 0 only
//   step         current step index (0-based)
//   busy         high in any non-idle state
//   sim_done     one-cycle pulse on normal completion
//   timeout_err  sticky watchdog flag
// Modports: master drives the requests/responses (environment),
//           slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface sim_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int STEP_W    = 16
);
    logic                 ui_done;
    logic [STEP_W-1:0]    num_steps;
    logic                 abort;
    logic [NUM_LANES-1:0] pusher_done;
    logic [NUM_LANES-1:0] scatter_done;
    logic                 solve_done;
    logic                 pusher_valid;
    logic                 start_solve;
    logic                 first;
    logic [STEP_W-1:0]    step;
    logic                 busy;
    logic                 sim_done;
    logic                 timeout_err;

    modport master (
        output ui_done, num_steps, abort, pusher_done, scatter_done, solve_done,
        input  pusher_valid, start_solve, first, step, busy, sim_done, timeout_err
    );

    modport slave (
        input  ui_done, num_steps, abort, pusher_done, scatter_done, solve_done,
        output pusher_valid, start_solve, first, step, busy, sim_done, timeout_err
    );
endinterface

// File: rtl/sim_sequencer.sv
// ---------------------------------------------------------------------------
// sim_sequencer
// Purpose : top-level timestep sequencer for the particle-in-cell engine.
//           Runs num_steps timesteps; each step is PUSH_SCATTER, SCATTER,
//           SOLVE across NUM_LANES lanes whose completions may arrive in
//           different cycles. The final step ends after PUSH_SCATTER.
//           Includes a step counter, abort, and a per-phase watchdog.
// Ports   :
//   clk    clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    sim_sequencer_if.slave (requests in, status out)
// ---------------------------------------------------------------------------
module sim_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int STEP_W    = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    sim_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_SCAT  = 2'd2,
        ST_SOLVE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_LANES-1:0] r_done_mask;
    logic [NUM_LANES-1:0] w_done_mask;
    logic [NUM_LANES-1:0] w_incoming;
    logic [STEP_W-1:0]    r_num_steps;
    logic [STEP_W-1:0]    w_num_steps;
    logic [STEP_W-1:0]    r_step;
    logic [STEP_W-1:0]    w_step;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [TIMEOUT_W-1:0] w_wdog;
    logic [TIMEOUT_W-1:0] w_wdog_inc;
    logic                 w_phase_done;
    logic                 w_timeout;
    logic                 w_sim_done;
    logic                 w_timeout_err;
    logic                 w_state_change;

    logic                 r_pusher_valid;
    logic                 r_start_solve;
    logic                 r_first;
    logic                 r_busy;
    logic                 r_sim_done;
    logic                 r_timeout_err;

    // Lane completions only count in the phase they belong to.
    always_comb begin
        w_incoming = '0;
        case (r_state)
            ST_PUSH: w_incoming = bus.pusher_done;
            ST_SCAT: w_incoming = bus.scatter_done;
            default: w_incoming = '0;
        endcase
    end

    // Lanes done earlier and lanes done this cycle are treated alike.
    assign w_phase_done = &(r_done_mask | w_incoming);

    // r_wdog counts cycles already spent in the phase; the phase expires on
    // the cycle in which the count would reach all-ones, i.e. after
    // 2^TIMEOUT_W-1 cycles in one state.
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_timeout  = (r_state != ST_IDLE) && (w_wdog_inc == '1);

    always_comb begin
        w_next_state  = r_state;
        w_num_steps   = r_num_steps;
        w_step        = r_step;
        w_sim_done    = 1'b0;
        w_timeout_err = r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.ui_done) begin
                    w_timeout_err = 1'b0;
                    if (bus.num_steps != '0) begin
                        w_num_steps  = bus.num_steps;
                        w_step       = '0;
                        w_next_state = ST_PUSH;
                    end else begin
                        w_sim_done = 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                // Completion outranks a watchdog expiry in the same cycle.
                if (w_phase_done) begin
                    if (r_step == r_num_steps - 1'b1) begin
                        w_next_state = ST_IDLE;
                        w_sim_done   = 1'b1;
                    end else begin
                        w_next_state = ST_SCAT;
                    end
                end else if (w_timeout) begin
                    w_next_state  = ST_IDLE;
                    w_timeout_err = 1'b1;
                end
            end
            ST_SCAT: begin
                if (w_phase_done) begin
                    w_next_state = ST_SOLVE;
                end else if (w_timeout) begin
                    w_next_state  = ST_IDLE;
                    w_timeout_err = 1'b1;
                end
            end
            ST_SOLVE: begin
                if (bus.solve_done) begin
                    w_step       = r_step + 1'b1;
                    w_next_state = ST_PUSH;
                end else if (w_timeout) begin
                    w_next_state  = ST_IDLE;
                    w_timeout_err = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        // Abort overrides everything, including a start or completion.
        if (bus.abort) begin
            w_next_state  = ST_IDLE;
            w_num_steps   = r_num_steps;
            w_step        = r_step;
            w_sim_done    = 1'b0;
            w_timeout_err = r_timeout_err;
        end
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_done_mask    = (w_state_change || bus.abort) ? '0 : (r_done_mask | w_incoming);
    assign w_wdog         = (w_state_change || r_state == ST_IDLE) ? '0 : w_wdog_inc;

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_done_mask    <= '0;
            r_num_steps    <= '0;
            r_step         <= '0;
            r_wdog         <= '0;
            r_pusher_valid <= 1'b0;
            r_start_solve  <= 1'b0;
            r_first        <= 1'b0;
            r_busy         <= 1'b0;
            r_sim_done     <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_done_mask    <= w_done_mask;
            r_num_steps    <= w_num_steps;
            r_step         <= w_step;
            r_wdog         <= w_wdog;
            r_pusher_valid <= (w_next_state == ST_PUSH);
            r_start_solve  <= (w_next_state == ST_SOLVE);
            r_first        <= (w_next_state == ST_PUSH) && (w_step == '0);
            r_busy         <= (w_next_state != ST_IDLE);
            r_sim_done     <= w_sim_done;
            r_timeout_err  <= w_timeout_err;
        end
    end

    assign bus.pusher_valid = r_pusher_valid;
    assign bus.start_solve  = r_start_solve;
    assign bus.first        = r_first;
    assign bus.step         = r_step;
    assign bus.busy         = r_busy;
    assign bus.sim_done     = r_sim_done;
    assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_sim_sequencer.sv
`timescale 1ns/1ps
module tb_sim_sequencer;
    localparam int NL    = 4;
    localparam int SW    = 4;
    localparam int TW    = 4;
    localparam int LIMIT = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sim_sequencer_if #(.NUM_LANES(NL), .STEP_W(SW)) bus ();

    sim_sequencer #(.NUM_LANES(NL), .STEP_W(SW), .TIMEOUT_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: phase number, cycles spent in the phase, lanes seen.
    int m_phase;   // 0 idle, 1 push_scatter, 2 scatter, 3 solve
    int m_cycles;
    int m_step;
    int m_total;
    bit m_terr;
    bit m_pulse;
    bit m_got [NL];

    typedef struct {
        bit          ui;
        int          n;
        logic [3:0]  pd;
        logic [3:0]  sd;
        bit          sv;
        logic [9:0]  exp;  // {pv, ss, first, busy, done, terr, step[3:0]}
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(bit ui, int n, logic [3:0] pd, logic [3:0] sd, bit sv, logic [9:0] exp);
        vec_t v;
        v.ui = ui; v.n = n; v.pd = pd; v.sd = sd; v.sv = sv; v.exp = exp;
        return v;
    endfunction

    function automatic logic [9:0] dut_word();
        return {bus.pusher_valid, bus.start_solve, bus.first, bus.busy,
                bus.sim_done, bus.timeout_err, bus.step};
    endfunction

    function automatic logic [9:0] model_word();
        logic [SW-1:0] s;
        s = SW'(m_step);
        return {(m_phase == 1), (m_phase == 3), (m_phase == 1 && m_step == 0),
                (m_phase != 0), m_pulse, m_terr, s};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cycles = 0; m_step = 0; m_total = 0;
        m_terr = 0; m_pulse = 0;
        for (int i = 0; i < NL; i++) m_got[i] = 0;
    endtask

    task automatic model_apply();
        int np;
        bit all;
        logic [NL-1:0] inc;
        np = m_phase; m_pulse = 0; inc = '0;
        if (m_phase == 1) inc = bus.pusher_done;
        else if (m_phase == 2) inc = bus.scatter_done;
        if (bus.abort) begin
            np = 0;
        end else if (m_phase == 0) begin
            if (bus.ui_done) begin
                m_terr = 0;
                if (bus.num_steps != 0) begin
                    m_total = int'(bus.num_steps); m_step = 0; np = 1;
                end else begin
                    m_pulse = 1;
                end
            end
        end else begin
            all = 1;
            for (int i = 0; i < NL; i++) if (!m_got[i] && !inc[i]) all = 0;
            if (m_phase == 3) all = bus.solve_done;
            if (all) begin
                if (m_phase == 1 && m_step == m_total - 1) begin np = 0; m_pulse = 1; end
                else if (m_phase == 3) begin m_step++; np = 1; end
                else np = m_phase + 1;
            end else if (m_cycles + 1 >= LIMIT) begin
                np = 0; m_terr = 1;
            end
        end
        if (np != m_phase || bus.abort || np == 0) begin
            for (int i = 0; i < NL; i++) m_got[i] = 0;
            m_cycles = 0;
        end else begin
            for (int i = 0; i < NL; i++) m_got[i] = m_got[i] | inc[i];
            m_cycles++;
        end
        m_phase = np;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (dut_word() !== model_word()) begin
            errors++;
            $display("FAIL model_cmp cycle %0d: got %b expected %b", cyc, dut_word(), model_word());
        end
    endtask

    task automatic drive(input bit ui, input int n, input bit ab,
                         input logic [NL-1:0] pd, input logic [NL-1:0] sd, input bit sv);
        bus.ui_done      = ui;
        bus.num_steps    = SW'(n);
        bus.abort        = ab;
        bus.pusher_done  = pd;
        bus.scatter_done = sd;
        bus.solve_done   = sv;
        tick();
    endtask

    bit         r_ui, r_ab, r_sv;
    int         r_n;
    logic [3:0] r_pd, r_sd;

    initial begin
        bus.ui_done = 0; bus.num_steps = '0; bus.abort = 0;
        bus.pusher_done = '0; bus.scatter_done = '0; bus.solve_done = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset_outputs", int'(dut_word()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main scenario: 3 steps, all lanes together, 1-cycle responders.
        tbl[0] = mk(1, 3, 4'h0, 4'h0, 0, 10'b1011000000);
        tbl[1] = mk(0, 0, 4'hF, 4'h0, 0, 10'b0001000000);
        tbl[2] = mk(0, 0, 4'h0, 4'hF, 0, 10'b0101000000);
        tbl[3] = mk(0, 0, 4'h0, 4'h0, 1, 10'b1001000001);
        tbl[4] = mk(0, 0, 4'hF, 4'h0, 0, 10'b0001000001);
        tbl[5] = mk(0, 0, 4'h0, 4'hF, 0, 10'b0101000001);
        tbl[6] = mk(0, 0, 4'h0, 4'h0, 1, 10'b1001000010);
        tbl[7] = mk(0, 0, 4'hF, 4'h0, 0, 10'b0000100010);
        tbl[8] = mk(0, 0, 4'h0, 4'h0, 0, 10'b0000000010);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ui, tbl[i].n, 0, tbl[i].pd, tbl[i].sd, tbl[i].sv);
            chk($sformatf("table_row%0d", i), int'(dut_word()), int'(tbl[i].exp));
        end

        // Staggered lanes, then pusher re-pulse during SCATTER.
        drive(1, 2, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 4'b0001, 4'h0, 0);
        chk("stag_hold1_pv", int'(bus.pusher_valid), 1);
        drive(0, 0, 0, 4'b0100, 4'h0, 0);
        chk("stag_hold2_pv", int'(bus.pusher_valid), 1);
        drive(0, 0, 0, 4'b1010, 4'h0, 0);
        chk("stag_enter_scatter", int'({bus.pusher_valid, bus.start_solve, bus.busy}), 1);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        chk("stag_repulse_ignored", int'({bus.pusher_valid, bus.start_solve, bus.busy}), 1);
        drive(0, 0, 0, 4'hF, 4'b0111, 0);
        chk("stag_scatter_partial", int'(bus.start_solve), 0);
        drive(0, 0, 0, 4'h0, 4'b1000, 0);
        chk("stag_enter_solve", int'(bus.start_solve), 1);
        drive(0, 0, 0, 4'h0, 4'h0, 1);
        chk("stag_step1", int'(bus.step), 1);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        chk("stag_sim_done", int'({bus.busy, bus.sim_done}), 1);

        // num_steps = 0.
        drive(1, 0, 0, 4'h0, 4'h0, 0);
        chk("zero_steps_pulse", int'({bus.busy, bus.sim_done}), 1);
        drive(0, 0, 0, 4'h0, 4'h0, 0);
        chk("zero_steps_pulse_end", int'(bus.sim_done), 0);

        // Abort with the final scatter_done of step 1.
        drive(1, 3, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        drive(0, 0, 0, 4'h0, 4'hF, 0);
        drive(0, 0, 0, 4'h0, 4'h0, 1);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        drive(0, 0, 1, 4'h0, 4'hF, 0);
        chk("abort_idle", int'({bus.busy, bus.start_solve, bus.sim_done}), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 4'h0, 4'h0, 0);
            chk("abort_quiet", int'({bus.start_solve, bus.sim_done, bus.busy}), 0);
        end

        // Watchdog in SOLVE.
        drive(1, 2, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        drive(0, 0, 0, 4'h0, 4'hF, 0);
        for (int k = 0; k < LIMIT - 1; k++) begin
            drive(0, 0, 0, 4'h0, 4'h0, 0);
            chk($sformatf("wd_solve_hold%0d", k), int'(bus.start_solve), 1);
        end
        drive(0, 0, 0, 4'h0, 4'h0, 0);
        chk("wd_expired", int'({bus.start_solve, bus.busy, bus.timeout_err, bus.sim_done}), 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 4'h0, 4'h0, 0);
            chk("wd_sticky", int'(bus.timeout_err), 1);
        end
        drive(1, 1, 0, 4'h0, 4'h0, 0);
        chk("wd_cleared", int'(bus.timeout_err), 0);
        chk("wd_restart_first", int'({bus.pusher_valid, bus.first, bus.step}), 8'h30);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        chk("one_step_done", int'({bus.busy, bus.sim_done}), 1);

        // Largest num_steps: step reaches 14 and never wraps.
        drive(1, 15, 0, 4'h0, 4'h0, 0);
        for (int s = 0; s < 15; s++) begin
            drive(0, 0, 0, 4'hF, 4'h0, 0);
            if (s < 14) begin
                drive(0, 0, 0, 4'h0, 4'hF, 0);
                drive(0, 0, 0, 4'h0, 4'h0, 1);
            end
        end
        chk("max_steps_final", int'({bus.sim_done, bus.step}), 8'h1E);

        // Asynchronous reset mid-SCATTER.
        drive(1, 3, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 4'hF, 4'h0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(dut_word()), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        drive(1, 2, 0, 4'h0, 4'h0, 0);
        chk("post_reset_restart", int'({bus.pusher_valid, bus.first, bus.busy, bus.step}), 8'h70);

        // Randomized traffic against the model, with quiet windows for timeouts.
        for (int k = 0; k < 2500; k++) begin
            r_ui = ($urandom_range(0, 3) == 0);
            r_n  = $urandom_range(0, 4);
            r_ab = ($urandom_range(0, 79) == 0);
            r_pd = 4'($urandom) & 4'($urandom);
            r_sd = 4'($urandom) & 4'($urandom);
            r_sv = ($urandom_range(0, 3) == 0);
            if ((k % 300) >= 270) begin
                r_pd = 4'h0; r_sd = 4'h0; r_sv = 0;
            end
            drive(r_ui, r_n, r_ab, r_pd, r_sd, r_sv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
